// File: rtl/home_pkg.sv
// home_pkg: controller states and display codes shared across the home controller
package home_pkg;
  typedef enum logic [2:0] {IDLE, FIRE, DOOR, WINDOW, HEAT, COOL} state_t;
  localparam logic [2:0] DISP_IDLE = 3'd0;
  localparam logic [2:0] DISP_DOOR = 3'd1;
  localparam logic [2:0] DISP_WIN  = 3'd2;
  localparam logic [2:0] DISP_FIRE = 3'd3;
  localparam logic [2:0] DISP_HEAT = 3'd4;
  localparam logic [2:0] DISP_COOL = 3'd5;
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: registers a raw bit and accepts a change only after DEB_CYCLES stable cycles
module sensor_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic raw,
  output logic filt
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic raw_q, filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    filt_d = (raw_q != filt_q && cnt_q == CW'(DEB_CYCLES - 1)) ? raw_q : filt_q;
    cnt_d = (raw_q == filt_q || filt_d != filt_q) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      raw_q <= 1'b0;
      filt_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      raw_q <= raw;
      filt_q <= filt_d;
      cnt_q <= cnt_d;
    end
  end
  assign filt = filt_q;
endmodule

// File: rtl/home_ctrl_multi.sv
// home_ctrl_multi: debounced multi-door/window/fire controller with fire latch and hysteretic climate control
module home_ctrl_multi
  import home_pkg::*;
#(
  parameter int N_DOORS    = 2,
  parameter int N_WIN      = 4,
  parameter int TEMP_W     = 7,
  parameter int T_LOW      = 50,
  parameter int T_HIGH     = 60,
  parameter int HYST       = 2,
  parameter int DEB_CYCLES = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [N_DOORS-1:0] SD,
  input  logic [N_WIN-1:0]   SW,
  input  logic               SFA,
  input  logic               Ack,
  input  logic [TEMP_W-1:0]  ST,
  output logic [N_DOORS-1:0] door_open,
  output logic               winbuzz,
  output logic               alarmbuzz,
  output logic               heater,
  output logic               cooler,
  output logic [2:0]         display,
  output logic [2:0]         chan
);
  localparam int NS = N_DOORS + N_WIN + 1;
  logic [NS-1:0] raw, filt;
  logic [N_DOORS-1:0] door_f, door_open_q, door_open_d;
  logic [N_WIN-1:0] win_f;
  logic sfa_f, heat, cool;
  logic [2:0] door_idx, win_idx, display_q, display_d, chan_q, chan_d;
  logic fire_q, fire_d, winbuzz_q, winbuzz_d, alarmbuzz_q, alarmbuzz_d;
  logic heater_q, heater_d, cooler_q, cooler_d;
  state_t state_q, state_d;
  assign raw = {SFA, SW, SD};
  for (genvar g = 0; g < NS; g++) begin : g_deb
    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (.Clk(Clk), .Rst(Rst), .raw(raw[g]), .filt(filt[g]));
  end
  assign door_f = filt[N_DOORS-1:0];
  assign win_f = filt[N_DOORS +: N_WIN];
  assign sfa_f = filt[NS-1];
  always_comb begin
    door_idx = '0;
    for (int i = N_DOORS - 1; i >= 0; i--) if (door_f[i]) door_idx = 3'(i);
    win_idx = '0;
    for (int i = N_WIN - 1; i >= 0; i--) if (win_f[i]) win_idx = 3'(i);
    fire_d = sfa_f | (fire_q & ~Ack);
    heat = int'(ST) < T_LOW || (state_q == HEAT && int'(ST) < T_LOW + HYST);
    cool = int'(ST) > T_HIGH || (state_q == COOL && int'(ST) > T_HIGH - HYST);
    state_d = fire_d ? FIRE : |door_f ? DOOR : |win_f ? WINDOW : heat ? HEAT : cool ? COOL : IDLE;
    door_open_d = (state_d == DOOR) ? N_DOORS'(1) << door_idx : '0;
    winbuzz_d = state_d == WINDOW;
    alarmbuzz_d = state_d == FIRE;
    heater_d = state_d == HEAT;
    cooler_d = state_d == COOL;
    display_d = state_d == FIRE ? DISP_FIRE : state_d == DOOR ? DISP_DOOR : state_d == WINDOW ? DISP_WIN :
                state_d == HEAT ? DISP_HEAT : state_d == COOL ? DISP_COOL : DISP_IDLE;
    chan_d = state_d == DOOR ? door_idx : state_d == WINDOW ? win_idx : '0;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      fire_q <= 1'b0;
      door_open_q <= '0;
      winbuzz_q <= 1'b0;
      alarmbuzz_q <= 1'b0;
      heater_q <= 1'b0;
      cooler_q <= 1'b0;
      display_q <= DISP_IDLE;
      chan_q <= '0;
    end else begin
      state_q <= state_d;
      fire_q <= fire_d;
      door_open_q <= door_open_d;
      winbuzz_q <= winbuzz_d;
      alarmbuzz_q <= alarmbuzz_d;
      heater_q <= heater_d;
      cooler_q <= cooler_d;
      display_q <= display_d;
      chan_q <= chan_d;
    end
  end
  assign door_open = door_open_q;
  assign winbuzz = winbuzz_q;
  assign alarmbuzz = alarmbuzz_q;
  assign heater = heater_q;
  assign cooler = cooler_q;
  assign display = display_q;
  assign chan = chan_q;
endmodule

// File: doc/home_ctrl_multi.md
# home_ctrl_multi

Parametrised, multi-channel successor to the single-door home-automation controller. It debounces N door sensors, M window sensors and one fire sensor, and arbitrates them with fixed priority. Fire alarms latch until acknowledged. The temperature loop uses hysteresis, and the display reports a mode code plus the index of the active channel. It sits between the raw sensor pins and the actuator/display drivers.

## Interface
- N_DOORS, 2, number of door sensors (1..8)
- N_WIN, 4, number of window sensors (1..8)
- TEMP_W, 7, temperature word width, unsigned
- T_LOW, 50, heat when ST < T_LOW
- T_HIGH, 60, cool when ST > T_HIGH; T_LOW + HYST <= T_HIGH - HYST is required
- HYST, 2, hysteresis margin
- DEB_CYCLES, 4, consecutive stable cycles required to accept a sensor change (>= 1)
- Clk  in  1  single clock, rising edge
- Rst  in  1  synchronous, active-high reset
- SD  in  N_DOORS  raw door sensors, 1 = person detected
- SW  in  N_WIN  raw window sensors, 1 = open
- SFA  in  1  raw fire sensor
- Ack  in  1  alarm acknowledge, level
- ST  in  TEMP_W  temperature sample
- door_open  out  N_DOORS  one-hot open command for the selected door
- winbuzz, alarmbuzz, heater, cooler  out  1 each  actuators
- display  out  3  mode code
- chan  out  3  index of the selected door or window, 0 otherwise

## Operation
- Every sensor bit (SD, SW, SFA) passes through its own debouncer.
  - Raw input is registered once.
  - A counter increments while the registered raw value differs from the filtered value, and clears when they match.
  - The filtered value flips when the counter reaches DEB_CYCLES - 1.
- Fire latch:
  - Set on filtered SFA = 1.
  - Cleared only on a cycle where Ack = 1 and filtered SFA = 0.
  - Ack while filtered SFA = 1 is ignored.
- State machine states: IDLE, FIRE, DOOR, WINDOW, HEAT, COOL. Next state is evaluated every cycle with priority:
  - FIRE if the latch is set.
  - Otherwise DOOR if any filtered door bit = 1; select the lowest index.
  - Otherwise WINDOW if any filtered window bit = 1; select the lowest index.
  - Otherwise temperature:
    - HEAT if ST < T_LOW.
    - If already in HEAT, remain while ST < T_LOW + HYST.
    - COOL if ST > T_HIGH.
    - If already in COOL, remain while ST > T_HIGH - HYST.
  - Otherwise IDLE.
- Output decode per state:
  - FIRE: alarmbuzz = 1, display = 3.
  - DOOR: door_open = one-hot(sel), display = 1, chan = sel.
  - WINDOW: winbuzz = 1, display = 2, chan = sel.
  - HEAT: heater = 1, display = 4.
  - COOL: cooler = 1, display = 5.
  - IDLE: all outputs 0, display = 0.
  - All outputs not listed for a state are 0.
- A higher-priority event preempts a lower one on the next edge. When a door preempts HEAT, the heater drops in the same cycle that door_open rises.
- When a window is open, heater and cooler are forced off. This is implied by the priority order.

## Timing
- Reset: at the Rst edge, all outputs = 0, display = 0, chan = 0, state = IDLE, fire latch cleared, debounce counters and filtered values = 0. Reset mid-alarm clears the latch unconditionally.
- Outputs are registered decodes of the next state, so state and outputs update on the same edge.
- Latency: a raw change held stable from edge k updates the outputs at edge k + DEB_CYCLES + 1.
- A glitch shorter than DEB_CYCLES cycles has no effect on any output.
- Ack-to-release: the FIRE outputs drop one edge after an Ack is sampled with filtered SFA = 0.
- ST is not debounced. It is sampled directly each cycle; hysteresis provides the stability.
- Simultaneous door changes on one edge: the lowest asserted index wins. If the selected door clears while another is still set, chan moves to the next lowest index on the following edge with no IDLE gap.

## Structure
- Package home_pkg holds:
  - the state enum (IDLE, FIRE, DOOR, WINDOW, HEAT, COOL);
  - display code constants DISP_IDLE = 0, DISP_DOOR = 1, DISP_WIN = 2, DISP_FIRE = 3, DISP_HEAT = 4, DISP_COOL = 5.
- Sub-module sensor_debounce (parameter DEB_CYCLES; ports Clk, Rst, raw, filt) is instantiated N_DOORS + N_WIN + 1 times.
- Priority encoders for the door and window selects stay inline.

## Test plan
- Reset: hold Rst for 2 cycles with all sensors asserted -> all outputs 0, display = 0; normal operation resumes DEB_CYCLES + 1 cycles after release.
- Debounce (DEB_CYCLES = 4):
  - 3-cycle pulse on SD[1] -> no output change.
  - 6-cycle pulse on SD[1] -> door_open = 2'b10, display = 1, chan = 1, starting 5 edges after the pulse starts.
- Priority:
  - Set SW[2] = 1 and ST = 40 (HEAT) -> winbuzz = 1, heater = 0, display = 2, chan = 2.
  - Then assert SFA -> alarmbuzz = 1, display = 3, winbuzz = 0.
- Fire latch:
  - Drop SFA, leave Ack = 0 -> FIRE persists.
  - Pulse Ack while SFA = 1 -> ignored.
  - Pulse Ack after SFA has filtered low -> FIRE exits one edge later into WINDOW or IDLE.
- Hysteresis (T_LOW = 50, HYST = 2):
  - ST = 49 -> heater = 1.
  - ST = 51 -> heater stays 1.
  - ST = 52 -> heater = 0, display = 0.
  - ST = 61 -> cooler = 1.
  - ST = 59 -> cooler = 1.
  - ST = 58 -> cooler = 0.
- Multi-door: SD = 2'b11 -> chan = 0; release SD[0] -> chan = 1 after DEB_CYCLES + 1 edges with no IDLE cycle.
